// File: rtl/fake68k_master.sv
// 68000-style asynchronous bus master: one S-state per clk, DTACK/BERR handshake.
// Define FAKE68K_TIMEOUT_EN to add an S4 watchdog that raises an internal bus error.
module fake68k_master #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [2:0]          req_fc,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_berr,
  output logic                rsp_timeout,
  output logic [3:0]          state,
  input  logic                dtack_n,
  input  logic                berr_n,
  output wire  [2:0]          fc,
  output wire  [ADDR_W-1:0]   addr,
  inout  wire  [DATA_W-1:0]   data,
  output logic                as_n,
  output logic [DATA_W/8-1:0] ds_n,
  output logic                rw
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [3:0] {
    S0   = 4'd0,
    S1   = 4'd1,
    S2   = 4'd2,
    S3   = 4'd3,
    S4   = 4'd4,
    S5   = 4'd5,
    S6   = 4'd6,
    S7   = 4'd7,
    B1   = 4'd8,
    B2   = 4'd10,
    IDLE = 4'd15
  } state_t;

  state_t              state_reg, state_next;
  logic                write_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [NB-1:0]       be_reg;
  logic [2:0]          fc_reg;
  logic                b1_cnt_reg;
  logic                rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic                rsp_berr_reg;
  logic                rsp_fire;
  logic                tmo_hit;
  logic                tmo_flag;
  logic                fc_oe, addr_oe, data_oe;
  logic [DATA_W-1:0]   rd_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign rd_mask[gi*8 +: 8] = {8{be_reg[gi]}};
    end
  endgenerate

`ifdef FAKE68K_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmo_cnt_reg;
  logic          tmo_flag_reg;
  logic          rsp_timeout_reg;

  // Counter is zero on the first S4 cycle; it fires on the TIMEOUT_CYC-th one.
  assign tmo_hit  = (state_reg == S4) && dtack_n && berr_n &&
                    (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));
  assign tmo_flag = tmo_flag_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_reg     <= '0;
      tmo_flag_reg    <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      tmo_cnt_reg <= (state_reg == S4) ? tmo_cnt_reg + 1'b1 : '0;
      if (tmo_hit)
        tmo_flag_reg <= 1'b1;
      else if (state_reg == IDLE || state_reg == S7)
        tmo_flag_reg <= 1'b0;
      if (rsp_fire)
        rsp_timeout_reg <= (state_reg == B2) && tmo_flag_reg;
    end
  end
  assign rsp_timeout = rsp_timeout_reg;
`else
  assign tmo_hit     = 1'b0;
  assign tmo_flag    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    rsp_fire   = 1'b0;
    req_ready  = 1'b0;
    fc_oe      = 1'b0;
    addr_oe    = 1'b0;
    data_oe    = 1'b0;
    as_n       = 1'b1;
    ds_n       = '1;
    rw         = 1'b1;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S0;
      end
      S0: begin
        fc_oe      = 1'b1;
        rw         = ~write_reg;
        state_next = S1;
      end
      S1: begin
        fc_oe      = 1'b1;
        addr_oe    = 1'b1;
        rw         = ~write_reg;
        state_next = S2;
      end
      S2, S3: begin
        fc_oe      = 1'b1;
        addr_oe    = 1'b1;
        rw         = ~write_reg;
        as_n       = 1'b0;
        data_oe    = write_reg && (state_reg == S3);
        if (!write_reg) ds_n = ~be_reg;
        state_next = (state_reg == S2) ? S3 : S4;
      end
      S4, S5, S6, B1: begin
        fc_oe   = 1'b1;
        addr_oe = 1'b1;
        rw      = ~write_reg;
        as_n    = 1'b0;
        ds_n    = ~be_reg;
        data_oe = write_reg;
        if (state_reg == S4) begin
          // berr_n takes priority over a simultaneous dtack_n
          if (!berr_n)       state_next = B1;
          else if (!dtack_n) state_next = S5;
          else if (tmo_hit)  state_next = B1;
        end else if (state_reg == S5) begin
          state_next = S6;
        end else if (state_reg == S6) begin
          state_next = S7;
        end else if (b1_cnt_reg) begin
          state_next = B2;
        end
      end
      S7: begin
        req_ready  = 1'b1;
        fc_oe      = 1'b1;
        addr_oe    = 1'b1;
        rw         = ~write_reg;
        data_oe    = write_reg;
        rsp_fire   = 1'b1;
        state_next = req_valid ? S0 : IDLE;
      end
      B2: begin
        // A watchdog error has no external BERR to wait out
        if (berr_n || tmo_flag) begin
          state_next = IDLE;
          rsp_fire   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      fc_reg        <= '0;
      b1_cnt_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_berr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (req_ready && req_valid) begin
        write_reg <= req_write;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        be_reg    <= req_be;
        fc_reg    <= req_fc;
      end
      b1_cnt_reg <= (state_reg == B1) ? ~b1_cnt_reg : 1'b0;
      if (state_reg == S6 && !write_reg)
        rsp_rdata_reg <= data & rd_mask;
      rsp_valid_reg <= rsp_fire;
      if (rsp_fire)
        rsp_berr_reg <= (state_reg == B2);
    end
  end

  assign state     = state_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_berr  = rsp_berr_reg;
  assign fc        = fc_oe   ? fc_reg    : 3'bzzz;
  assign addr      = addr_oe ? addr_reg  : {ADDR_W{1'bz}};
  assign data      = data_oe ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: doc/fake68k_master.md
FAKE68K_MASTER -- requirements
Module: fake68k_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 24, address bus width in bits (1..32)
- DATA_W, 16, data bus width in bits (8 or 16)
- TIMEOUT_CYC, 64, clk cycles spent in S4 before an internal bus error; only used with FAKE68K_TIMEOUT_EN
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; one S-state per posedge
- reset_n, in, 1, asynchronous active-low reset
- req_valid, in, 1, cycle request
- req_ready, out, 1, request accepted this cycle
- req_write, in, 1, 1 = write cycle, 0 = read cycle
- req_addr, in, ADDR_W, cycle address
- req_wdata, in, DATA_W, write data
- req_be, in, DATA_W/8, byte enables; bit 1 = upper lane
- req_fc, in, 3, function code
- rsp_valid, out, 1, one-cycle completion pulse
- rsp_rdata, out, DATA_W, latched read data
- rsp_berr, out, 1, cycle ended by bus error
- rsp_timeout, out, 1, bus error was internal
- state, out, 4, current state code, for debug
- dtack_n, in, 1, data transfer acknowledge
- berr_n, in, 1, bus error
- fc, out (tri-state), 3, function code
- addr, out (tri-state), ADDR_W, address bus
- data, inout, DATA_W, data bus
- as_n, out, 1, address strobe
- ds_n, out, DATA_W/8, data strobes (UDS/LDS)
- rw, out, 1, 1 = read

Function
REQ-003 States and codes SHALL be: IDLE=15, S0..S7=0..7, B1=8, B2=10.
REQ-004 In IDLE, req_ready SHALL be 1; req_valid=1 latches all req_* fields and moves to S0.
REQ-005 In IDLE, fc, addr and data SHALL be Z, as_n and ds_n all 1, and rw 1.
REQ-006 S0: fc SHALL be driven; addr SHALL stay Z; rw = ~req_write.
REQ-007 S1: addr SHALL be driven.
REQ-008 S2: as_n=0; for a read, ds_n[i]=~be[i].
REQ-009 S3: for a write, data SHALL be driven.
REQ-010 S4: for a write, ds_n[i]=~be[i].
REQ-011 The machine SHALL hold in S4 until dtack_n=0 or berr_n=0 is sampled; berr_n wins if both are low.
REQ-012 S4 SHALL go to S5 on dtack_n=0 and to B1 on berr_n=0.
REQ-013 S5 and S6 SHALL hold all strobes.
REQ-014 For a read, the S6 to S7 edge SHALL latch data into rsp_rdata; lanes with be=0 read as 0.
REQ-015 S7: as_n and ds_n SHALL be 1; addr, fc and write data stay driven.
REQ-016 At the S7 exit, rsp_valid SHALL pulse for 1 cycle.
REQ-017 On S7 exit with req_valid=1, the next request SHALL be latched (req_ready=1 in S7) and the machine goes to S0; otherwise it goes to IDLE.
REQ-018 B1 SHALL hold addr and strobes for 2 cycles, then go to B2.
REQ-019 In B2, addr and data SHALL be Z and all strobes negated.
REQ-020 B2 SHALL wait for berr_n=1, then go to IDLE with rsp_valid=1, rsp_berr=1 and rsp_rdata unchanged.
REQ-021 The machine SHALL never drive data during a read.
REQ-022 req_ready SHALL be 0 in all states except IDLE and S7.
REQ-023 A req_valid=0 at S7 exit SHALL force IDLE.

Reset
REQ-024 reset_n=0 SHALL immediately (asynchronously) force IDLE from any state and set:
- req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_berr=0, rsp_timeout=0
- fc, addr and data Z
- as_n=1, ds_n all 1, rw=1
REQ-025 Reset mid-cycle SHALL abort the cycle with no rsp_valid.
REQ-026 Release of reset SHALL start no cycle until req_valid is sampled in IDLE.

Configuration
REQ-027 With FAKE68K_TIMEOUT_EN defined:
- a counter SHALL clear on S4 entry and count clks in S4
- when the count reaches TIMEOUT_CYC with neither dtack_n nor berr_n low, the machine goes to B1 with rsp_timeout=1
- B2 then goes to IDLE after one cycle, ignoring berr_n
REQ-028 Without FAKE68K_TIMEOUT_EN, S4 SHALL wait indefinitely, the counter is absent and rsp_timeout is constant 0.

Verification
REQ-029 Read: addr=120, fc=3, be=11, bus data 7F7F, dtack_n low at the 3rd S4 cycle -> as_n and ds_n low S2-S6, rsp_rdata=7F7F at S7 exit, rsp_valid for 1 clk.
REQ-030 Write: addr=40, wdata=A55A, be=01 -> data driven from S3, ds_n=10 in S4-S6, rw=0, as_n low S2-S6, rsp_berr=0.
REQ-031 BERR: addr=BEEF, berr_n low in S4 -> B1 for 2 clks with strobes held, B2 with addr Z, exit 1 clk after berr_n high, rsp_berr=1.
REQ-032 Back-to-back: two reads with req_valid held and dtack_n tied low -> second S0 directly after first S7, no IDLE between.
REQ-033 Reset: reset_n low in S5 of a write -> data and addr Z and as_n=1 within the same timestep, no rsp_valid.
REQ-034 Timeout (macro on, TIMEOUT_CYC=8): dtack_n and berr_n held high -> B1 after 8 S4 cycles, rsp_berr=1, rsp_timeout=1.
